// File: rtl/tinyalu_core.sv
// tinyalu_core: registered 8-bit ALU (add/and/xor) with a start/done handshake.
// Optional pipelined multiplier enabled by defining TINYALU_MUL_EN; MUL_STAGES
// sets its command-to-done latency.
module tinyalu_core #(
    parameter int MUL_STAGES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_RST = 3'b111;

    if (MUL_STAGES < 2 || MUL_STAGES > 6) begin : g_bad_stages
        $error("tinyalu_core: MUL_STAGES must be in 2..6");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
`ifdef TINYALU_MUL_EN
        BUSY     = 2'd1,
`endif
        WAIT_REL = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        pend, pend_next;       // single-cycle op captured, result due next edge
    logic        capture;               // latch operands on this edge
    logic        done_next;
    logic [15:0] result_next;
    logic [7:0]  a_q, b_q;
    logic [2:0]  op_q;

`ifdef TINYALU_MUL_EN
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] CNT_INIT = 3'(MUL_STAGES - 1);

    logic [2:0]  cnt;                    // edges left before the product is ready
    logic [15:0] mul_pipe [MUL_STAGES-1];
    logic        released, released_next; // start dropped while multiplying
    logic        mul_launch;
`endif

    // Single-cycle datapath; anything not listed (including opcodes with no
    // single-cycle meaning) produces zero.
    function automatic logic [15:0] alu_value(input logic [2:0] code,
                                              input logic [7:0] x,
                                              input logic [7:0] y);
        case (code)
            OP_ADD:  return {7'b0, {1'b0, x} + {1'b0, y}};
            OP_AND:  return {8'b0, x & y};
            OP_XOR:  return {8'b0, x ^ y};
            default: return 16'h0000;
        endcase
    endfunction

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next  = state;
        pend_next   = 1'b0;
        capture     = 1'b0;
        done_next   = 1'b0;
        result_next = result;
`ifdef TINYALU_MUL_EN
        mul_launch    = 1'b0;
        released_next = released;
`endif
        case (state)
            IDLE: begin
                if (pend) begin
                    done_next   = 1'b1;
                    result_next = alu_value(op_q, a_q, b_q);
                    state_next  = WAIT_REL;
                end else if (start && op != OP_NOP && op != OP_RST) begin
                    capture = 1'b1;
`ifdef TINYALU_MUL_EN
                    if (op == OP_MUL) begin
                        mul_launch    = 1'b1;
                        released_next = 1'b0;
                        state_next    = BUSY;
                    end else begin
                        pend_next = 1'b1;
                    end
`else
                    pend_next = 1'b1;
`endif
                end
            end
`ifdef TINYALU_MUL_EN
            BUSY: begin
                if (!start) released_next = 1'b1;
                if (cnt == 3'd0) begin
                    done_next   = 1'b1;
                    result_next = mul_pipe[MUL_STAGES-2];
                    state_next  = (released || !start) ? IDLE : WAIT_REL;
                end
            end
`endif
            WAIT_REL: begin
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            pend   <= 1'b0;
            done   <= 1'b0;
            result <= 16'h0000;
`ifdef TINYALU_MUL_EN
            released <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            pend   <= pend_next;
            done   <= done_next;
            result <= result_next;
`ifdef TINYALU_MUL_EN
            released <= released_next;
`endif
        end
    end

    // Operand latches: loaded only at command capture so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            op_q <= 3'b000;
        end else if (capture) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op;
        end
    end

`ifdef TINYALU_MUL_EN
    // Multiplier pipeline and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
            // NOTE: the pipeline array is explicitly cleared so an aborted product never resurfaces.
            for (int i = 0; i < MUL_STAGES - 1; i++) mul_pipe[i] <= 16'h0000;
        end else begin
            mul_pipe[0] <= {8'b0, a_q} * {8'b0, b_q};
            for (int i = 1; i < MUL_STAGES - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
            if (mul_launch)
                cnt <= CNT_INIT;
            else if (state == BUSY && cnt != 3'd0)
                cnt <= cnt - 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tinyalu_core.sv
// tb_tinyalu_core: table-driven directed vectors, hand-written reset/handshake
// sequences and randomized commands checked against a behavioural model.
module tb_tinyalu_core;

    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a, b;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_result;   // model of the result register

    tinyalu_core #(.MUL_STAGES(STAGES)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (a),
        .B      (b),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [2:0]  vop;
        int          extra;    // clocks start stays high after done
        int          lat;      // expected done latency from capture, 0 = no done
        logic [15:0] res;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: what a command does, from the opcode table.
    task automatic ref_exec(input logic [2:0] o, input int x, input int y,
                            output int lat, output logic [15:0] r);
        case (o)
            3'd0, 3'd7: begin lat = 0; r = exp_result; end
            3'd1:       begin lat = 1; r = 16'(x + y); end
            3'd2:       begin lat = 1; r = 16'(x & y); end
            3'd3:       begin lat = 1; r = 16'(x ^ y); end
`ifdef TINYALU_MUL_EN
            3'd4:       begin lat = STAGES; r = 16'(x * y); end
`endif
            default:    begin lat = 1; r = 16'h0000; end
        endcase
    endtask

    // Issue one command, hold start per the handshake, and check it.
    task automatic run_cmd(input string name, input logic [7:0] ca, input logic [7:0] cb,
                           input logic [2:0] cop, input int extra, input int exp_lat,
                           input logic [15:0] exp_res);
        int          pulses;
        int          first;
        logic [15:0] got;
        pulses = 0;
        first  = -1;
        got    = 16'h0000;
        a = ca; b = cb; op = cop; start = 1'b1;
        tick();                                   // E0
        check({name, " done@E0"}, 32'(done), 32'd0);
        if (exp_lat == 0) begin
            start = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (done) pulses++;
            end
        end else begin
            a  = 8'($urandom);                    // in-flight command must ignore these
            b  = 8'($urandom);
            op = 3'($urandom);
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (done) begin
                    pulses++;
                    if (first < 0) begin
                        first = k;
                        got   = result;
                    end
                end
                if (first >= 0 && k >= first + extra) break;
            end
            start = 1'b0;
            tick();
            if (done) pulses++;
            check({name, " latency"}, 32'(first), 32'(exp_lat));
            check({name, " result"}, 32'(got), 32'(exp_res));
            exp_result = exp_res;
        end
        check({name, " pulses"}, 32'(pulses), (exp_lat == 0) ? 32'd0 : 32'd1);
        check({name, " hold"}, 32'(result), 32'(exp_result));
    endtask

    vec_t vecs[$];

    initial begin
        int          pulses;
        int          first;
        int          lat;
        logic [15:0] r;
        logic [7:0]  ra, rb;
        logic [2:0]  rop;

        vecs.push_back('{"add_ff_01",  8'hFF, 8'h01, 3'b001, 0, 1, 16'h0100});
`ifdef TINYALU_MUL_EN
        vecs.push_back('{"mul_ff_ff",  8'hFF, 8'hFF, 3'b100, 0, STAGES, 16'hFE01});
`else
        vecs.push_back('{"mul_ff_ff",  8'hFF, 8'hFF, 3'b100, 0, 1, 16'h0000});
`endif
        vecs.push_back('{"xor_held",   8'hA5, 8'h0F, 3'b011, 4, 1, 16'h00AA});
        vecs.push_back('{"no_op",      8'h12, 8'h34, 3'b000, 0, 0, 16'h00AA});
        vecs.push_back('{"rst_op",     8'h56, 8'h78, 3'b111, 0, 0, 16'h00AA});
        vecs.push_back('{"b2b_add",    8'h10, 8'h20, 3'b001, 0, 1, 16'h0030});
        vecs.push_back('{"b2b_xor",    8'hF0, 8'h0F, 3'b011, 0, 1, 16'h00FF});
        vecs.push_back('{"and_3c_0f",  8'h3C, 8'h0F, 3'b010, 1, 1, 16'h000C});
        vecs.push_back('{"add_ff_ff",  8'hFF, 8'hFF, 3'b001, 0, 1, 16'h01FE});
        vecs.push_back('{"illegal_5",  8'h11, 8'h22, 3'b101, 0, 1, 16'h0000});
        vecs.push_back('{"add_after",  8'h01, 8'h02, 3'b001, 0, 1, 16'h0003});
        vecs.push_back('{"illegal_6",  8'h33, 8'h44, 3'b110, 2, 1, 16'h0000});

        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000;
        exp_result = 16'h0000;
        tick();
        tick();
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        reset = 1'b0;

        foreach (vecs[i])
            run_cmd(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vop,
                    vecs[i].extra, vecs[i].lat, vecs[i].res);

        // Reset has priority over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = 3'b001; a = 8'h01; b = 8'h01;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        check("reset_prio done", 32'(done), 32'd0);
        check("reset_prio result", 32'(result), 32'd0);
        exp_result = 16'h0000;

        // Load a non-zero result, then reset in the middle of a multiply.
        run_cmd("pre_abort", 8'h05, 8'h06, 3'b011, 0, 1, 16'h0003);
        a = 8'hFF; b = 8'hFF; op = 3'b100; start = 1'b1;
        tick();                                   // E0
        reset = 1'b1;
        tick();                                   // E0+1, reset wins
        reset = 1'b0; start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) pulses++;
        end
        check("abort pulses", 32'(pulses), 32'd0);
        check("abort result", 32'(result), 32'd0);
        exp_result = 16'h0000;

        // First edge with reset low and start high captures the command.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_cmd("and_after_reset", 8'h03, 8'h04, 3'b010, 0, 1, 16'h0000);

`ifdef TINYALU_MUL_EN
        // Start released during the multiply: done still fires, FSM goes straight to IDLE.
        a = 8'd12; b = 8'd34; op = 3'b100; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        first = -1;
        r = 16'h0000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done && first < 0) begin
                first = k;
                r = result;
                break;
            end
        end
        check("early_release latency", 32'(first), 32'(STAGES));
        check("early_release result", 32'(r), 32'd408);
        exp_result = 16'd408;
        run_cmd("add_after_release", 8'h01, 8'h02, 3'b001, 0, 1, 16'h0003);
`endif

        // Randomized commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom_range(0, 7));
            ref_exec(rop, int'(ra), int'(rb), lat, r);
            run_cmd($sformatf("rand%0d_op%0d", n, rop), ra, rb, rop,
                    int'($urandom_range(0, 3)), lat, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
